// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - types and constants shared by the data-memory port arbiter
package mem_arb_pkg;
  localparam int WORD_BITS = 32;
  localparam logic [2:0] FETCH_MODE = 3'b010;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} arb_state_t;
  typedef enum logic {REQ_IF, REQ_LS} req_id_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory-side signals of the port arbiter
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic                 if_req;
  logic [WORD_BITS-1:0] if_addr;
  logic                 if_flush;
  logic                 if_gnt;
  logic                 if_rvalid;
  logic [WORD_BITS-1:0] if_rdata;

  logic                 ls_req;
  logic                 ls_we;
  logic [2:0]           ls_mode;
  logic [WORD_BITS-1:0] ls_addr;
  logic [WORD_BITS-1:0] ls_wdata;
  logic                 ls_gnt;
  logic                 ls_rvalid;
  logic [WORD_BITS-1:0] ls_rdata;

  logic                 mem_req;
  logic                 mem_we;
  logic [2:0]           mem_mode;
  logic [WORD_BITS-1:0] mem_addr;
  logic [WORD_BITS-1:0] mem_wdata;
  logic                 mem_ack;
  logic [WORD_BITS-1:0] mem_rdata;
  logic                 mem_err;

  // master: requesters plus memory model; slave: the arbiter
  modport master (
    output if_req, if_addr, if_flush, ls_req, ls_we, ls_mode, ls_addr, ls_wdata,
           mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_req, mem_we, mem_mode, mem_addr, mem_wdata, mem_err
  );

  modport slave (
    input  if_req, if_addr, if_flush, ls_req, ls_we, ls_mode, ls_addr, ls_wdata,
           mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_req, mem_we, mem_mode, mem_addr, mem_wdata, mem_err
  );
endinterface

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - counts BUSY cycles and flags expiry on the MAX_WAIT-th cycle without ack
module mem_arb_watchdog #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic busy,
  output logic expire
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (busy && wait_cnt != LAST) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign expire = busy && (wait_cnt == LAST);
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store, LS priority with anti-starvation
// Optional timeout abort when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int MAX_WAIT = 15
`endif
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  arb_state_t    state, state_nxt;
  logic [SW-1:0] starve_cnt;
  logic          flush_pend;
  logic          ls_win;
  logic          expire;
  logic          done;

  assign ls_win = bus.ls_req && (!bus.if_req || starve_cnt < LIMIT);
  assign done   = (state != IDLE) && (bus.mem_ack || expire);

`ifdef MEM_ARB_TIMEOUT_EN
  logic grant;
  assign grant = bus.ls_gnt || bus.if_gnt;

  mem_arb_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant),
    .busy   (state != IDLE),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ls_win)          state_nxt = BUSY_LS;
        else if (bus.if_req) state_nxt = BUSY_IF;
      end
      default: begin
        if (bus.mem_ack || expire) state_nxt = IDLE;
      end
    endcase
  end

  // grants are combinational but masked while reset is held
  always_comb begin
    bus.ls_gnt = 1'b0;
    bus.if_gnt = 1'b0;
    if (state == IDLE && !rst) begin
      bus.ls_gnt = ls_win;
      bus.if_gnt = !ls_win && bus.if_req;
    end
  end

  assign bus.mem_req = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt    <= '0;
      flush_pend    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_mode  <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.ls_rvalid <= 1'b0;
      bus.ls_rdata  <= '0;
      bus.mem_err   <= 1'b0;
    end else begin
      bus.if_rvalid <= 1'b0;
      bus.ls_rvalid <= 1'b0;
      bus.mem_err   <= expire && !bus.mem_ack;

      if (bus.ls_gnt) begin
        bus.mem_we    <= bus.ls_we;
        bus.mem_mode  <= bus.ls_mode;
        bus.mem_addr  <= bus.ls_addr;
        bus.mem_wdata <= bus.ls_wdata;
        if (!bus.if_req)              starve_cnt <= '0;
        else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end else if (bus.if_gnt) begin
        bus.mem_we    <= 1'b0;
        bus.mem_mode  <= FETCH_MODE;
        bus.mem_addr  <= bus.if_addr;
        bus.mem_wdata <= '0;
        starve_cnt    <= '0;
      end else if (state == IDLE && !bus.if_req) begin
        starve_cnt <= '0;
      end

      if (state == BUSY_IF && done)
        flush_pend <= 1'b0;
      else if (bus.if_flush && (state == BUSY_IF || bus.if_gnt))
        flush_pend <= 1'b1;

      // an aborted transfer still completes toward the requester, with zero data
      if (done && state == BUSY_LS) begin
        bus.ls_rvalid <= 1'b1;
        bus.ls_rdata  <= (bus.mem_we || !bus.mem_ack) ? '0 : bus.mem_rdata;
      end
      if (done && state == BUSY_IF && !flush_pend && !bus.if_flush) begin
        bus.if_rvalid <= 1'b1;
        bus.if_rdata  <= bus.mem_ack ? bus.mem_rdata : '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed, table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // busy: 0 = IDLE, 1 = fetch in flight, 2 = load/store in flight
  typedef struct {
    logic        ifr;
    logic        lsr;
    logic        ack;
    logic [31:0] rd;
    logic        ig;
    logic        lg;
    logic [1:0]  busy;
    logic        ivld;
    logic        lvld;
    logic [31:0] vdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ifr, input logic lsr, input logic ack,
                              input logic [31:0] rd, input logic ig, input logic lg,
                              input logic [1:0] busy, input logic ivld, input logic lvld,
                              input logic [31:0] vdata);
    vec_t v;
    v.ifr = ifr; v.lsr = lsr; v.ack = ack; v.rd = rd;
    v.ig = ig; v.lg = lg; v.busy = busy; v.ivld = ivld; v.lvld = lvld; v.vdata = vdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h80; bus.if_flush = 1'b0;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_mode = 3'b000;
    bus.ls_addr = 32'h40; bus.ls_wdata = 32'h1111_1111;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst if_gnt", bus.if_gnt, 0);
    chk("rst ls_gnt", bus.ls_gnt, 0);
    chk("rst mem_req", bus.mem_req, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst if_rvalid", bus.if_rvalid, 0);
    chk("rst ls_rvalid", bus.ls_rvalid, 0);
    chk("rst mem_err", bus.mem_err, 0);
    rst = 1'b0;
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;

    // cycle table: single-shot LS then IF, then 4 LS : 1 IF rotation under contention
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'hA1, 0, 0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,  1, 0, 0, 0, 1, 32'hA1));
    vecs.push_back(mk(0, 0, 1, 32'h13, 0, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 0, 0, 1, 0, 32'h13));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'hB1, 0, 0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 1, 0, 0, 1, 32'hB1));
    vecs.push_back(mk(1, 1, 1, 32'hB2, 0, 0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 1, 0, 0, 1, 32'hB2));
    vecs.push_back(mk(1, 1, 1, 32'hB3, 0, 0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 1, 0, 0, 1, 32'hB3));
    vecs.push_back(mk(1, 1, 1, 32'hB4, 0, 0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 0, 0, 0, 1, 32'hB4));
    vecs.push_back(mk(1, 1, 1, 32'hC1, 0, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 1, 0, 1, 0, 32'hC1));
    vecs.push_back(mk(1, 1, 1, 32'hB5, 0, 0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 0, 0, 0, 1, 32'hB5));

    step();
    for (int i = 0; i < vecs.size(); i++) begin
      bus.if_req    = vecs[i].ifr;
      bus.ls_req    = vecs[i].lsr;
      bus.mem_ack   = vecs[i].ack;
      bus.mem_rdata = vecs[i].rd;
      #4;
      chk($sformatf("v%0d if_gnt", i), bus.if_gnt, vecs[i].ig);
      chk($sformatf("v%0d ls_gnt", i), bus.ls_gnt, vecs[i].lg);
      chk($sformatf("v%0d mem_req", i), bus.mem_req, vecs[i].busy != 0);
      chk($sformatf("v%0d if_rvalid", i), bus.if_rvalid, vecs[i].ivld);
      chk($sformatf("v%0d ls_rvalid", i), bus.ls_rvalid, vecs[i].lvld);
      if (vecs[i].busy != 0) begin
        chk($sformatf("v%0d mem_addr", i), bus.mem_addr, (vecs[i].busy == 1) ? 32'h80 : 32'h40);
        chk($sformatf("v%0d mem_mode", i), bus.mem_mode, (vecs[i].busy == 1) ? 3'b010 : 3'b000);
        chk($sformatf("v%0d mem_we", i), bus.mem_we, 0);
      end
      if (vecs[i].ivld) chk($sformatf("v%0d if_rdata", i), bus.if_rdata, vecs[i].vdata);
      if (vecs[i].lvld) chk($sformatf("v%0d ls_rdata", i), bus.ls_rdata, vecs[i].vdata);
      step();
    end
    bus.mem_ack = 1'b0;

    // store held for five unacked cycles, inputs scrambled after grant
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h100;
    bus.ls_wdata = 32'hDEAD_BEEF; bus.ls_mode = 3'b010; bus.mem_rdata = 32'h5555_5555;
    #4 chk("st ls_gnt", bus.ls_gnt, 1);
    step();
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = 32'hFFFF_0000;
    bus.ls_wdata = 32'h0; bus.ls_mode = 3'b000;
    for (int k = 0; k < 5; k++) begin
      #4;
      chk($sformatf("st%0d mem_req", k), bus.mem_req, 1);
      chk($sformatf("st%0d mem_we", k), bus.mem_we, 1);
      chk($sformatf("st%0d mem_addr", k), bus.mem_addr, 32'h100);
      chk($sformatf("st%0d mem_wdata", k), bus.mem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("st%0d mem_mode", k), bus.mem_mode, 3'b010);
      chk($sformatf("st%0d ls_rvalid", k), bus.ls_rvalid, 0);
      step();
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    #4 chk("st ack mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    step();
    bus.mem_ack = 1'b0;
    #4;
    chk("st ls_rvalid", bus.ls_rvalid, 1);
    chk("st ls_rdata", bus.ls_rdata, 0);
    chk("st mem_req after", bus.mem_req, 0);
    step();
    #4 chk("st rvalid pulse", bus.ls_rvalid, 0);
    step();
    bus.ls_addr = 32'h40;

    // flush while fetch is in flight; next fetch returns back-to-back
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    #4 chk("fl1 if_gnt", bus.if_gnt, 1);
    step();
    bus.if_req = 1'b0; bus.if_flush = 1'b1;
    #4 chk("fl1 mem_req", bus.mem_req, 1);
    step();
    bus.if_flush = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0013;
    step();
    bus.mem_ack = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h204;
    #4;
    chk("fl1 if_rvalid", bus.if_rvalid, 0);
    chk("fl1 regrant", bus.if_gnt, 1);
    step();
    bus.if_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0050_0093;
    #4 chk("fl1 mem_addr", bus.mem_addr, 32'h204);
    step();
    bus.mem_ack = 1'b0;
    #4;
    chk("fl1 next rvalid", bus.if_rvalid, 1);
    chk("fl1 next rdata", bus.if_rdata, 32'h0050_0093);
    step();

    // flush in the grant cycle
    bus.if_req = 1'b1; bus.if_flush = 1'b1;
    #4 chk("fl2 if_gnt", bus.if_gnt, 1);
    step();
    bus.if_req = 1'b0; bus.if_flush = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAAAA_AAAA;
    step();
    bus.mem_ack = 1'b0;
    #4 chk("fl2 if_rvalid", bus.if_rvalid, 0);
    step();

    // flush coincident with ack, then flush in IDLE has no effect
    bus.if_req = 1'b1;
    #4 chk("fl3 if_gnt", bus.if_gnt, 1);
    step();
    bus.if_req = 1'b0; bus.if_flush = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBBBB_BBBB;
    step();
    bus.mem_ack = 1'b0;
    #4;
    chk("fl3 if_rvalid", bus.if_rvalid, 0);
    chk("fl3 idle no gnt", bus.if_gnt, 0);
    step();
    bus.if_flush = 1'b0; bus.if_req = 1'b1;
    #4 chk("fl4 if_gnt", bus.if_gnt, 1);
    step();
    bus.if_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0BAD;
    step();
    bus.mem_ack = 1'b0;
    #4;
    chk("fl4 if_rvalid", bus.if_rvalid, 1);
    chk("fl4 if_rdata", bus.if_rdata, 32'h0000_0BAD);
    step();

    // reset while a load is outstanding
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h300;
    #4 chk("rs ls_gnt", bus.ls_gnt, 1);
    step();
    bus.ls_req = 1'b0;
    #4 chk("rs mem_req busy", bus.mem_req, 1);
    rst = 1'b1;
    #1 chk("rs mem_req drop", bus.mem_req, 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCCCC_CCCC;
    step();
    rst = 1'b0; bus.mem_ack = 1'b0;
    #4;
    chk("rs ls_rvalid", bus.ls_rvalid, 0);
    chk("rs mem_req", bus.mem_req, 0);
    step();
    #4 chk("rs ls_rvalid late", bus.ls_rvalid, 0);
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    // no ack for MAX_WAIT cycles aborts the load
    bus.ls_req = 1'b1; bus.ls_addr = 32'h400;
    #4 chk("to ls_gnt", bus.ls_gnt, 1);
    step();
    bus.ls_req = 1'b0;
    for (int k = 0; k < 15; k++) begin
      #4;
      chk($sformatf("to%0d mem_req", k), bus.mem_req, 1);
      chk($sformatf("to%0d mem_err", k), bus.mem_err, 0);
      step();
    end
    #4;
    chk("to mem_err", bus.mem_err, 1);
    chk("to ls_rvalid", bus.ls_rvalid, 1);
    chk("to ls_rdata", bus.ls_rdata, 0);
    chk("to mem_req", bus.mem_req, 0);
    step();
    #4 chk("to mem_err pulse", bus.mem_err, 0);
    step();

    // ack in the expiry cycle wins
    bus.ls_req = 1'b1;
    #4 chk("ta ls_gnt", bus.ls_gnt, 1);
    step();
    bus.ls_req = 1'b0;
    for (int k = 0; k < 14; k++) step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0077;
    step();
    bus.mem_ack = 1'b0;
    #4;
    chk("ta mem_err", bus.mem_err, 0);
    chk("ta ls_rvalid", bus.ls_rvalid, 1);
    chk("ta ls_rdata", bus.ls_rdata, 32'h0000_0077);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
